// File: rtl/bcd_countdown.sv
// BCD countdown timer: loads a preset, decrements once per prescaler tick
// while running, and flags expiry when the count reaches zero.
//
// Ports:
//   CLK     - system clock, rising edge
//   R       - asynchronous active-high reset
//   LOAD    - load PRESET (digits above 9 load as 9), return to IDLE
//   PRESET  - BCD preset value, digit 0 least significant
//   START   - start from IDLE, or resume from PAUSED
//   STOP    - pause while running (wins over START)
//   COUNT   - current BCD value, registered
//   RUNNING - high while in RUN
//   DONE    - high while in DONE
//   EXPIRE  - one-cycle pulse on the edge the count reaches zero

module bcd_countdown #(
    parameter int NDIG     = 2,
    parameter int TICK_DIV = 100000000
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              LOAD,
    input  logic [4*NDIG-1:0] PRESET,
    input  logic              START,
    input  logic              STOP,
    output logic [4*NDIG-1:0] COUNT,
    output logic              RUNNING,
    output logic              DONE,
    output logic              EXPIRE
);

    localparam int CW = 4 * NDIG;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_n;
    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_n;
    logic            expire_n;
    logic [CW-1:0]   preset_clean;
    logic [CW-1:0]   count_dec;

    // Clamp any non-BCD preset digit to 9 so COUNT only ever holds
    // valid digits.
    function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement: zeros become 9 until the first
    // non-zero digit absorbs the borrow; higher digits are untouched.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign preset_clean = sanitize(PRESET);
    assign count_dec    = bcd_dec(count_q);

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state   <= S_IDLE;
            count_q <= '0;
            pre_q   <= '0;
            RUNNING <= 1'b0;
            DONE    <= 1'b0;
            EXPIRE  <= 1'b0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            pre_q   <= pre_n;
            RUNNING <= (state_n == S_RUN);
            DONE    <= (state_n == S_DONE);
            EXPIRE  <= expire_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count_q;
        pre_n    = pre_q;
        expire_n = 1'b0;

        if (LOAD) begin
            count_n = preset_clean;
            pre_n   = '0;
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START && !STOP && (count_q != '0)) begin
                        state_n = S_RUN;
                        pre_n   = '0;
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state_n = S_PAUSED;
                    end else if (pre_q == PMAX) begin
                        pre_n   = '0;
                        count_n = count_dec;
                        if (count_dec == '0) begin
                            state_n  = S_DONE;
                            expire_n = 1'b1;
                        end
                    end else begin
                        pre_n = pre_q + PW'(1);
                    end
                end
                S_PAUSED: begin
                    // Prescaler is left alone so the partial period
                    // already elapsed still counts after resuming.
                    if (START && !STOP) begin
                        state_n = S_RUN;
                    end
                end
                S_DONE: begin
                    count_n = '0;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign COUNT = count_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown (NDIG=2, TICK_DIV=4).
// Inputs change 1 time unit after a rising edge; outputs sampled there too.

module tb_bcd_countdown;

    logic       CLK;
    logic       R;
    logic       LOAD;
    logic [7:0] PRESET;
    logic       START;
    logic       STOP;
    logic [7:0] COUNT;
    logic       RUNNING;
    logic       DONE;
    logic       EXPIRE;

    int n_cmp = 0;
    int n_err = 0;

    bcd_countdown #(
        .NDIG     (2),
        .TICK_DIV (4)
    ) dut (
        .CLK     (CLK),
        .R       (R),
        .LOAD    (LOAD),
        .PRESET  (PRESET),
        .START   (START),
        .STOP    (STOP),
        .COUNT   (COUNT),
        .RUNNING (RUNNING),
        .DONE    (DONE),
        .EXPIRE  (EXPIRE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        int at;

        R      = 1'b1;
        LOAD   = 1'b0;
        PRESET = 8'h00;
        START  = 1'b0;
        STOP   = 1'b0;
        #2;
        chk("rst_count", COUNT, 8'h00);
        chk("rst_running", {7'd0, RUNNING}, 8'd0);
        chk("rst_done", {7'd0, DONE}, 8'd0);
        chk("rst_expire", {7'd0, EXPIRE}, 8'd0);
        step();
        R = 1'b0;
        step();

        // START with zero count is ignored
        START = 1'b1;
        step();
        START = 1'b0;
        chk("zero_start_run", {7'd0, RUNNING}, 8'd0);
        chk("zero_start_cnt", COUNT, 8'h00);

        // sanitized load
        LOAD   = 1'b1;
        PRESET = 8'hFA;
        step();
        LOAD = 1'b0;
        chk("load_fa", COUNT, 8'h99);

        // 03 down to expiry
        LOAD   = 1'b1;
        PRESET = 8'h03;
        step();
        LOAD  = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("run_03", {7'd0, RUNNING}, 8'd1);
        step(); step(); step();
        chk("hold_03", COUNT, 8'h03);
        step();
        chk("k4_02", COUNT, 8'h02);
        step(); step(); step(); step();
        chk("k8_01", COUNT, 8'h01);
        step(); step(); step();
        chk("k11_exp", {7'd0, EXPIRE}, 8'd0);
        step();
        chk("k12_cnt", COUNT, 8'h00);
        chk("k12_exp", {7'd0, EXPIRE}, 8'd1);
        chk("k12_done", {7'd0, DONE}, 8'd1);
        chk("k12_run", {7'd0, RUNNING}, 8'd0);
        step();
        chk("k13_exp", {7'd0, EXPIRE}, 8'd0);
        chk("k13_done", {7'd0, DONE}, 8'd1);

        // START in DONE is ignored
        START = 1'b1;
        step();
        START = 1'b0;
        chk("done_start_cnt", COUNT, 8'h00);
        chk("done_start_done", {7'd0, DONE}, 8'd1);
        chk("done_start_run", {7'd0, RUNNING}, 8'd0);

        // reload from DONE, expire after 8 cycles
        LOAD   = 1'b1;
        PRESET = 8'h02;
        step();
        LOAD = 1'b0;
        chk("reload_cnt", COUNT, 8'h02);
        chk("reload_done", {7'd0, DONE}, 8'd0);
        START = 1'b1;
        step();
        START  = 1'b0;
        pulses = 0;
        at     = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (EXPIRE) begin
                pulses++;
                at = i;
            end
        end
        chk("reload_pulses", 8'(pulses), 8'd1);
        chk("reload_at", 8'(at), 8'd8);

        // borrow 10 -> 09 -> 08
        LOAD   = 1'b1;
        PRESET = 8'h10;
        step();
        LOAD  = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        step(); step(); step(); step();
        chk("borrow_09", COUNT, 8'h09);
        step(); step(); step(); step();
        chk("borrow_08", COUNT, 8'h08);

        // pause after two prescaler counts, resume finishes period
        LOAD   = 1'b1;
        PRESET = 8'h05;
        step();
        LOAD  = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        step(); step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("pause_run", {7'd0, RUNNING}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_hold", COUNT, 8'h05);
        end
        START = 1'b1;
        step();
        START = 1'b0;
        chk("resume_run", {7'd0, RUNNING}, 8'd1);
        step();
        chk("resume_m1", COUNT, 8'h05);
        step();
        chk("resume_m2", COUNT, 8'h04);

        // START+STOP together pauses
        LOAD   = 1'b1;
        PRESET = 8'h07;
        step();
        LOAD  = 1'b0;
        START = 1'b1;
        step();
        STOP = 1'b1;
        step();
        START = 1'b0;
        STOP  = 1'b0;
        chk("both_run", {7'd0, RUNNING}, 8'd0);
        chk("both_cnt", COUNT, 8'h07);
        step(); step(); step(); step(); step();
        chk("both_hold", COUNT, 8'h07);

        // async reset mid-run
        START = 1'b1;
        step();
        START = 1'b0;
        chk("rerun", {7'd0, RUNNING}, 8'd1);
        step();
        #2;
        R = 1'b1;
        #1;
        chk("async_cnt", COUNT, 8'h00);
        chk("async_run", {7'd0, RUNNING}, 8'd0);
        #1;
        R = 1'b0;
        step();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("post_rst_run", {7'd0, RUNNING}, 8'd0);
        step(); step(); step(); step();
        chk("post_rst_cnt", COUNT, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
